// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and architectural constants.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    KILL,
    DATA,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC register, issues one outstanding
// instruction-memory read at a time and loads the IF/ID register.
module if_fetch_unit #(
  parameter int unsigned          DATA_SIZE = 32,
  parameter logic [DATA_SIZE-1:0] RESET_PC  = DATA_SIZE'(cpu_pkg::RESET_PC),
  parameter logic [DATA_SIZE-1:0] NOP_INSTR = DATA_SIZE'(cpu_pkg::NOP_INSTR)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] pc_data,
  input  logic                 pc_stall,
  input  logic                 flush,
  output logic [DATA_SIZE-1:0] pc,
  output logic [DATA_SIZE-1:0] next_pc,
  output logic                 bus_stall,
  output logic                 im_arvalid,
  output logic [DATA_SIZE-1:0] im_araddr,
  input  logic                 im_arready,
  input  logic                 im_rvalid,
  input  logic [DATA_SIZE-1:0] im_rdata,
  output logic                 im_rready,
  output logic [DATA_SIZE-1:0] id_instr,
  output logic [DATA_SIZE-1:0] id_pc,
  output logic                 id_valid
);

  import cpu_pkg::*;

  localparam logic [DATA_SIZE-1:0] PC_STEP = DATA_SIZE'(4);

  fetch_state_t         state_q;
  fetch_state_t         state_d;
  logic [DATA_SIZE-1:0] kill_addr_q;
  logic                 r_fire;
  logic                 accept;
  logic                 latch_kill;

  // Sequential successor of the current PC; wraps silently.
  assign next_pc = pc + PC_STEP;

  // PC register follows the PC controller every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= RESET_PC;
    else      pc <= pc_data;
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state, read-channel handshakes and stall back to the PC controller.
  always_comb begin
    state_d    = state_q;
    im_araddr  = pc;
    im_rready  = 1'b0;
    r_fire     = 1'b0;
    accept     = 1'b0;
    latch_kill = 1'b0;
    unique case (state_q)
      IDLE: state_d = ADDR;
      ADDR: begin
        if (im_arready) begin
          state_d = flush ? DRAIN : DATA;
        end else if (flush) begin
          state_d    = KILL;
          latch_kill = 1'b1;
        end
      end
      KILL: begin
        // Request already on the bus must stay stable until accepted.
        im_araddr = kill_addr_q;
        if (im_arready) state_d = DRAIN;
      end
      DATA: begin
        im_rready = ~pc_stall | flush;
        r_fire    = im_rvalid & (~pc_stall | flush);
        if (r_fire) begin
          state_d = ADDR;
          accept  = ~flush;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        im_rready = 1'b1;
        if (im_rvalid) state_d = ADDR;
      end
      default: state_d = IDLE;
    endcase
    bus_stall = ~r_fire & ~flush;
  end

  // Read-address valid is registered from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) im_arvalid <= 1'b0;
    else      im_arvalid <= (state_d == ADDR) || (state_d == KILL);
  end

  // Remember the address of a request that was flushed before acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            kill_addr_q <= '0;
    else if (latch_kill) kill_addr_q <= pc;
  end

  // IF/ID register: flush bubbles, stall holds, accepted response captures.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (flush) begin
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (accept && !pc_stall) begin
      id_instr <= im_rdata;
      id_pc    <= pc;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized scoreboard bench for if_fetch_unit with a memory stand-in and a
// program-order reference model of the fetch stream.
module tb_if_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } id_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_data, pc, next_pc, im_araddr, im_rdata, id_instr, id_pc;
  logic        pc_stall, flush, bus_stall, im_arvalid, im_arready;
  logic        im_rvalid, im_rready, id_valid;
  logic [31:0] target;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_pop = 0;

  // memory stand-in controls
  bit          mem_zero;
  bit          mem_hold;
  bit          pend;
  logic [31:0] m_addr;
  int          m_wait;

  // reference model state
  logic [31:0] exp_pc, fetch_addr;
  bit          ar_done, killed, started;
  bit          m_rhs, m_ahs;
  id_t         sb[$];

  // monitor state
  bit          cadence_on;
  bit          mp_valid, mp_flush, have_pop;
  logic [31:0] mp_pc;
  int          last_pop;
  id_t         e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PC controller stand-in: jump on flush, hold on stall, else advance.
  assign pc_data = flush ? target : ((bus_stall || pc_stall) ? pc : next_pc);

  if_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_data    (pc_data),
    .pc_stall   (pc_stall),
    .flush      (flush),
    .pc         (pc),
    .next_pc    (next_pc),
    .bus_stall  (bus_stall),
    .im_arvalid (im_arvalid),
    .im_araddr  (im_araddr),
    .im_arready (im_arready),
    .im_rvalid  (im_rvalid),
    .im_rdata   (im_rdata),
    .im_rready  (im_rready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_valid   (id_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    chk("rst_pc", pc, RPC);
    chk("rst_next_pc", next_pc, RPC + 32'd4);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_pc", id_pc, 32'h0);
    chk1("rst_id_valid", id_valid, 1'b0);
    chk1("rst_arvalid", im_arvalid, 1'b0);
    chk1("rst_rready", im_rready, 1'b0);
    chk1("rst_bus_stall", bus_stall, 1'b1);
  endtask

  // Instruction memory: instr = addr ^ KEY, random or zero wait states.
  initial begin
    im_arready = 1'b0;
    im_rvalid  = 1'b0;
    im_rdata   = '0;
    pend       = 1'b0;
    m_addr     = '0;
    m_wait     = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend = 1'b0;
      end else begin
        if (im_rvalid && im_rready) pend = 1'b0;
        if (im_arvalid && im_arready) begin
          pend   = 1'b1;
          m_addr = im_araddr;
          m_wait = mem_zero ? 0 : int'($urandom_range(0, 6));
        end
      end
      @(posedge clk);
      #1;
      if (!rst) begin
        im_arready = 1'b0;
        im_rvalid  = 1'b0;
      end else begin
        im_arready = mem_zero ? 1'b1 : ($urandom_range(0, 99) < 60);
        if (pend && !mem_hold && m_wait == 0) begin
          im_rvalid = 1'b1;
          im_rdata  = m_addr ^ KEY;
        end else begin
          im_rvalid = 1'b0;
          im_rdata  = $urandom;
          if (pend && !mem_hold && m_wait > 0) m_wait--;
        end
      end
    end
  end

  // Reference model: program-order fetch stream with redirects on flush.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_pc     = RPC;
        fetch_addr = RPC;
        ar_done    = 1'b0;
        killed     = 1'b0;
        started    = 1'b0;
        sb.delete();
      end else begin
        m_rhs = im_rvalid && im_rready;
        m_ahs = im_arvalid && im_arready;
        chk("pc", pc, exp_pc);
        chk("next_pc", next_pc, exp_pc + 32'd4);
        chk1("bus_stall", bus_stall, !(m_rhs && !killed) && !flush);
        chk1("arvalid", im_arvalid, started && !ar_done);
        chk1("rready", im_rready, ar_done && (killed || !pc_stall || flush));
        if (im_arvalid) chk("araddr", im_araddr, fetch_addr);
        if (flush) begin
          exp_pc = target;
          if (!started) fetch_addr = target;
          else if (!m_rhs) killed = 1'b1;
        end
        if (m_ahs) ar_done = 1'b1;
        if (m_rhs) begin
          if (!killed && !flush) begin
            sb.push_back(id_t'{instr: fetch_addr ^ KEY, pc: fetch_addr});
            exp_pc = exp_pc + 32'd4;
          end
          fetch_addr = exp_pc;
          ar_done    = 1'b0;
          killed     = 1'b0;
        end
        started = 1'b1;
      end
    end
  end

  // Monitor: compare each new IF/ID value against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mp_valid = 1'b0;
        mp_pc    = '0;
        mp_flush = 1'b0;
        have_pop = 1'b0;
      end else begin
        if (mp_flush) begin
          chk1("flush_id_valid", id_valid, 1'b0);
          chk("flush_id_instr", id_instr, NOP);
        end else if (id_valid && (!mp_valid || id_pc != mp_pc)) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL id_extra: got pc %h instr %h, nothing expected", id_pc, id_instr);
          end else begin
            e = sb.pop_front();
            n_pop++;
            chk("id_instr", id_instr, e.instr);
            chk("id_pc", id_pc, e.pc);
            if (cadence_on && have_pop) chk("cadence", 32'(cyc - last_pop), 32'd2);
            last_pop = cyc;
            have_pop = 1'b1;
          end
        end
        mp_valid = id_valid;
        mp_pc    = id_pc;
        mp_flush = flush;
      end
    end
  end

  // Stimulus: zero-wait stream, random stress, reset during drain, restart.
  initial begin
    rst        = 1'b0;
    flush      = 1'b0;
    pc_stall   = 1'b0;
    target     = '0;
    mem_zero   = 1'b1;
    mem_hold   = 1'b0;
    cadence_on = 1'b0;
    repeat (2) tick();
    check_reset();
    rst        = 1'b1;
    cadence_on = 1'b1;
    repeat (30) tick();

    cadence_on = 1'b0;
    mem_zero   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      flush = ($urandom_range(0, 99) < 7);
      if (flush) target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      pc_stall = ($urandom_range(0, 99) < 25);
      tick();
    end
    flush    = 1'b0;
    pc_stall = 1'b0;
    mem_zero = 1'b1;
    repeat (10) tick();

    mem_hold = 1'b1;
    for (int n = 0; n < 40 && !(ar_done && !killed); n++) tick();
    chk1("drain_setup", ar_done && !killed, 1'b1);
    flush  = 1'b1;
    target = 32'h0000_0100;
    tick();
    flush = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_reset();
    tick();
    mem_hold = 1'b0;
    repeat (2) tick();
    rst        = 1'b1;
    cadence_on = 1'b1;
    repeat (30) tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk1("enough_captures", n_pop > 100, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that owns the program-counter register and fetches instructions from instruction memory over a single-outstanding valid/ready read channel. Upstream, it consumes `pc_data` from the PC controller. Downstream, it drives the IF/ID instruction register. It generates `bus_stall` back to the PC controller while a fetch is incomplete, and discards in-flight fetches on a pipeline flush.

## Interface
- `DATA_SIZE`, 32, width of addresses and instructions
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `NOP_INSTR`, 32'h0000_0013, bubble instruction injected into IF/ID

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `pc_data`  in  DATA_SIZE  next PC from the PC controller; loaded into `pc` every cycle
- `pc_stall`  in  1  hazard stall; holds IF/ID and blocks response acceptance
- `flush`  in  1  taken jump/branch (`enable_jump & pc_jump_control`); kills the current fetch
- `pc`  out  DATA_SIZE  current PC register
- `next_pc`  out  DATA_SIZE  `pc + 4`, combinational
- `bus_stall`  out  1  fetch not complete; the PC controller holds the PC
- `im_arvalid` / `im_araddr` / `im_arready`  out 1 / out DATA_SIZE / in 1  read-address channel
- `im_rvalid` / `im_rdata` / `im_rready`  in 1 / in DATA_SIZE / out 1  read-data channel
- `id_instr` / `id_pc` / `id_valid`  out DATA_SIZE / DATA_SIZE / 1  IF/ID register outputs

## Operation
- `pc` register: `pc <= pc_data` every cycle. Hold behaviour comes from the PC controller via `bus_stall`/`pc_stall`.
- FSM states and transitions:
  - IDLE: one cycle after reset, then → ADDR.
  - ADDR: `im_arvalid=1`, `im_araddr=pc`.
    - `im_arready` → DATA.
    - `flush & im_arready` → DRAIN.
    - `flush & ~im_arready` → KILL, and latch `kill_addr_q <= pc`.
  - KILL: `im_arvalid=1`, `im_araddr=kill_addr_q`, held stable. On `im_arready` → DRAIN.
  - DATA: `im_rready = ~pc_stall | flush`.
    - On the handshake without `flush`: capture `id_instr <= im_rdata`, `id_pc <= pc`, `id_valid <= 1`, then → ADDR.
    - On the handshake with `flush`: discard, then → ADDR.
    - `flush` without handshake → DRAIN.
  - DRAIN: `im_rready=1`. The response is discarded; on `im_rvalid` → ADDR.
- `bus_stall = ~(state==DATA & im_rvalid & im_rready) & ~flush`.
  - `flush` always deasserts `bus_stall`, so the jump target is loaded into `pc` in the flush cycle.
- `flush` in DRAIN or KILL: `pc` updates, state is unchanged. Only one transaction is ever outstanding.
- IF/ID register priority:
  1. `flush`: `id_instr <= NOP_INSTR`, `id_valid <= 0`.
  2. `pc_stall`: hold.
  3. Accepted response: capture.
  4. Otherwise hold.
- `next_pc` wraps modulo 2^DATA_SIZE with no overflow flag.

## Timing
- Reset values:
  - `pc=RESET_PC`, `id_instr=NOP_INSTR`, `id_pc=0`, `id_valid=0`
  - state IDLE, `kill_addr_q=0`
  - `im_arvalid=0`, `im_rready=0`, `bus_stall=1`
- Reset asserted mid-transaction returns to IDLE immediately. The memory side is reset with the same `rst`.
- Minimum fetch interval is 2 cycles (ADDR accepted, then DATA responded).
  - `id_instr` is valid the cycle after the `im_rvalid & im_rready` handshake.
- First `im_arvalid` is asserted in the 2nd cycle after reset release, with `im_araddr=RESET_PC`.
- `im_arvalid` never drops and `im_araddr` never changes before `im_arready`. This is enforced by the KILL state.
- All outputs are registered except `bus_stall`, `next_pc`, `im_rready`, and `im_araddr` (decoded from state and registers).

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum {IDLE, ADDR, KILL, DATA, DRAIN}
  - `NOP_INSTR` and `RESET_PC` constants
- Single module, no sub-modules.
- Instantiated directly downstream of `pc_controller`: its `pc_data` output feeds this block, and this block's `pc`, `next_pc`, and `bus_stall` feed back into it.

## Test plan
- Reset, then memory with 0-wait `arready`/`rvalid` returning `im_rdata = addr ^ 32'hA5A5_0000` → araddr sequence 0, 4, 8; `id_instr` is 32'hA5A5_0000, 32'hA5A5_0004, …; one instruction every 2 cycles.
- `im_rvalid` delayed 5 cycles → `bus_stall=1` for the whole wait; `pc` held at 32'h4; `id_valid` holds its prior value.
- `flush` in DATA with jump target 32'h100, response arriving 3 cycles later with 32'hDEAD_BEEF → response discarded; `id_valid=0`, `id_instr=NOP`; next araddr is 32'h100.
- `flush` in ADDR while `im_arready=0` for 4 cycles → araddr stays at the old PC until accepted; response drained; then araddr is the jump target.
- `pc_stall=1` during DATA with `im_rvalid=1` → `im_rready=0`; `id_instr` held; capture occurs in the cycle `pc_stall` drops.
- Reset asserted in DRAIN → all outputs return to reset values asynchronously; the first fetch after release is to `RESET_PC`.
